// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM. Sequences each instruction
// through fetch/decode/execute/memory/write-back, waits on mem_ready with a
// timeout, and traps on illegal instructions or bus timeouts.
module multicycle_control #(
    parameter int unsigned ALUC_W  = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              BranchEq,
    output logic              BranchNeq,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic [1:0]        RegDst,
    output logic [1:0]        Mem2Reg,
    output logic [1:0]        ALUSrc1,
    output logic [1:0]        ALUSrc2,
    output logic              ExtOp,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [1:0]        PCSrc,
    output logic              instr_done,
    output logic              illegal,
    output logic              bus_error,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_READ = 4'd3,
        MEM_WB    = 4'd4,  MEM_WRITE = 4'd5, R_EXEC = 4'd6,  R_WB     = 4'd7,
        I_EXEC    = 4'd8,  I_WB   = 4'd9,  BRANCH   = 4'd10, JUMP     = 4'd11,
        JAL       = 4'd12, JR     = 4'd13, TRAP     = 4'd15
    } state_t;

    localparam int unsigned CW = $clog2(TIMEOUT);

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                           ALU_SLL = 3'b011, ALU_SRL = 3'b100, ALU_LUI = 3'b101,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111;

    localparam logic [5:0] OP_R   = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LUI = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08,
                           F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                           F_OR  = 6'h25, F_SLT = 6'h2A;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      opcode_q, opcode_d, func_q, func_d;
    logic            illegal_q, illegal_d, bus_error_q, bus_error_d;
    logic [2:0]      alu;
    logic            wait_st;

    function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
        state_t s;
        case (op)
            OP_R: begin
                case (fn)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: s = R_EXEC;
                    F_JR:    s = JR;
                    default: s = TRAP;
                endcase
            end
            OP_LW, OP_SW:                               s = MEM_ADDR;
            OP_BEQ, OP_BNE:                             s = BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:  s = I_EXEC;
            OP_J:                                       s = JUMP;
            OP_JAL:                                     s = JAL;
            default:                                    s = TRAP;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            F_ADD:   return ALU_ADD;
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_SLT:   return ALU_SLT;
            F_SLL:   return ALU_SLL;
            F_SRL:   return ALU_SRL;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            OP_ADDI: return ALU_ADD;
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_AND;
        endcase
    endfunction

    assign ALUControl = ALUC_W'(alu);

    // Next-state, wait counter, sticky flags and same-cycle datapath controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        opcode_d    = opcode_q;
        func_d      = func_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        wait_st     = 1'b0;
        PCWrite     = 1'b0;
        BranchEq    = 1'b0;
        BranchNeq   = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        Mem2Reg     = 2'b00;
        ALUSrc1     = 2'b00;
        ALUSrc2     = 2'b00;
        ExtOp       = 1'b0;
        alu         = ALU_AND;
        PCSrc       = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_error   = 1'b0;
        state       = FETCH;
        if (!reset) begin
            illegal   = illegal_q;
            bus_error = bus_error_q;
            state     = state_q;
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrc2 = 2'b01;
                    alu     = ALU_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    wait_st = 1'b1;
                    if (mem_ready) state_d = DECODE;
                end
                DECODE: begin
                    ALUSrc2  = 2'b11;
                    alu      = ALU_ADD;
                    opcode_d = opcode;
                    func_d   = func;
                    state_d  = dispatch(opcode, func);
                    if (state_d == TRAP) illegal_d = 1'b1;
                end
                MEM_ADDR: begin
                    ALUSrc1 = 2'b01;
                    ALUSrc2 = 2'b10;
                    alu     = ALU_ADD;
                    state_d = (opcode_q == OP_SW) ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    wait_st = 1'b1;
                    if (mem_ready) state_d = MEM_WB;
                end
                MEM_WB: begin
                    RegWrite   = 1'b1;
                    Mem2Reg    = 2'b01;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    wait_st  = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end
                R_EXEC: begin
                    alu     = r_alu(func_q);
                    ALUSrc1 = (func_q == F_SLL || func_q == F_SRL) ? 2'b10 : 2'b01;
                    state_d = R_WB;
                end
                R_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                I_EXEC: begin
                    ALUSrc1 = 2'b01;
                    ALUSrc2 = 2'b10;
                    alu     = i_alu(opcode_q);
                    ExtOp   = (opcode_q == OP_ANDI || opcode_q == OP_ORI || opcode_q == OP_LUI);
                    state_d = I_WB;
                end
                I_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                BRANCH: begin
                    ALUSrc1    = 2'b01;
                    alu        = ALU_SUB;
                    PCSrc      = 2'b01;
                    BranchEq   = (opcode_q == OP_BEQ);
                    BranchNeq  = (opcode_q == OP_BNE);
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JAL: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b10;
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    Mem2Reg    = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JR: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b11;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                TRAP:    state_d = TRAP;
                default: state_d = FETCH;
            endcase
            // Ready wins over timeout: only a still-low ready at the limit traps.
            if (wait_st && !mem_ready) begin
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State, counter, latched instruction fields and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            cnt_q       <= '0;
            opcode_q    <= '0;
            func_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            func_q      <= func_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle MIPS control unit, the successor to the single-cycle `control` block. It sequences each instruction through fetch, decode, execute, memory and write-back states, and waits on a shared-memory ready handshake with a timeout. It latches `opcode`/`func` in DECODE and drives the datapath muxes and write enables of the multicycle CPU. It traps on illegal instructions and on bus timeouts.

## Interface
- `ALUC_W`, default 3: ALUControl width. Codes occupy bits [2:0]; upper bits are driven 0.
- `TIMEOUT`, default 16: maximum consecutive wait cycles for `mem_ready` before a bus error. Must be ≥ 2.
- `clk` input, 1: single clock. All state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `opcode` input, 6: instruction [31:26] from the IR. Sampled in DECODE only.
- `func` input, 6: instruction [5:0] from the IR. Sampled in DECODE only.
- `mem_ready` input, 1: memory completes the current read or write this cycle.
- `PCWrite` output, 1: unconditional PC load.
- `BranchEq` output, 1: load PC if ALU zero.
- `BranchNeq` output, 1: load PC if ALU not zero.
- `IorD` output, 1: memory address source. 0 = PC, 1 = ALUOut.
- `MemRead` output, 1: memory read strobe.
- `MemWrite` output, 1: memory write strobe.
- `IRWrite` output, 1: instruction register load.
- `RegWrite` output, 1: register file write.
- `RegDst` output, 2: destination register. 00 = rt, 01 = rd, 10 = $31.
- `Mem2Reg` output, 2: write-back data. 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALUSrc1` output, 2: ALU A input. 00 = PC, 01 = rs, 10 = shamt.
- `ALUSrc2` output, 2: ALU B input. 00 = rt, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `ExtOp` output, 1: immediate extension. 1 = zero-extend, 0 = sign-extend.
- `ALUControl` output, ALUC_W: 000 and, 001 or, 010 add, 011 sll, 100 srl, 101 lui, 110 sub, 111 slt.
- `PCSrc` output, 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- `instr_done` output, 1: one-cycle pulse in the completing cycle of each instruction.
- `illegal` output, 1: sticky; set on an unsupported opcode or func.
- `bus_error` output, 1: sticky; set on a `mem_ready` timeout.
- `state` output, 4: current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JAL 12, JR 13, TRAP 15.
- All outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrc1=00, ALUSrc2=01, ALUControl=add.
  - IRWrite = PCWrite = `mem_ready`.
  - Go to DECODE on `mem_ready`, otherwise stay.
- DECODE: ALUSrc1=00, ALUSrc2=11, add (branch target into ALUOut). Latch opcode/func, then dispatch:
  - R-type (0x00) with func add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02 → R_EXEC.
  - R-type with func jr 0x08 → JR.
  - lw 0x23, sw 0x2B → MEM_ADDR.
  - beq 0x04, bne 0x05 → BRANCH.
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F → I_EXEC.
  - j 0x02 → JUMP. jal 0x03 → JAL.
  - Anything else → TRAP, with illegal=1.
- MEM_ADDR: ALUSrc1=01, ALUSrc2=10, add. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1. Go to MEM_WB on `mem_ready`.
- MEM_WB: RegWrite=1, RegDst=00, Mem2Reg=01, instr_done=1.
- MEM_WRITE: IorD=1, MemWrite=1. On `mem_ready`: instr_done=1, go to FETCH.
- R_EXEC: ALUSrc2=00; ALUControl from func. ALUSrc1=10 for sll/srl, 01 otherwise.
- R_WB: RegWrite=1, RegDst=01, Mem2Reg=00.
- I_EXEC: ALUSrc1=01, ALUSrc2=10. ALUControl: addi=add, slti=slt, andi=and, ori=or, lui=lui. ExtOp=1 for andi/ori/lui.
- I_WB: RegWrite=1, RegDst=00, Mem2Reg=00.
- BRANCH: ALUSrc1=01, ALUSrc2=00, sub, PCSrc=01. BranchEq=1 for beq, BranchNeq=1 for bne.
- JUMP: PCWrite=1, PCSrc=10.
- JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, Mem2Reg=10. PC still holds PC+4 in this cycle.
- JR: PCWrite=1, PCSrc=11.
- R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL, JR each assert instr_done and return to FETCH.
- Wait counter: counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with `mem_ready`=0. It clears on `mem_ready` and on any state change.
  - When the count reaches TIMEOUT-1 and `mem_ready` is still 0: go to TRAP with bus_error=1. No strobe is asserted in the following cycle.
- TRAP: all datapath outputs 0; sticky flags hold. Leaves only via reset.

## Timing
- While `reset`=1: all outputs 0, state=FETCH, counter=0, illegal=bus_error=0, latched opcode/func=0. The first cycle after release is a FETCH cycle.
- Outputs are decoded from state, latched opcode/func and `mem_ready` in the same cycle. There is no registered output delay.
- Cycles per instruction with `mem_ready` tied high:
  - R-type, I-type, sw: 4.
  - lw: 5.
  - beq, bne, j, jal, jr: 3.
- Each `mem_ready`=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `mem_ready` outside FETCH, MEM_READ and MEM_WRITE is ignored.
- `mem_ready` arriving in the same cycle the counter hits its limit completes the access normally. Ready takes priority over timeout.
- Reset asserted mid-instruction: outputs are 0 in that cycle and any pending access is abandoned.

## Test plan
- Reset release, then `mem_ready`=1 and add (opcode 0x00, func 0x20): states 0,1,6,7,0; RegDst=01 and RegWrite=1 in R_WB; instr_done high in cycle 4 only.
- lw (0x23) with `mem_ready` low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4; IorD=1 throughout MEM_READ; Mem2Reg=01 in MEM_WB; 7 cycles total.
- bne (0x05) then jal (0x03): BRANCH shows BranchNeq=1, PCSrc=01, ALUControl=110; JAL shows RegDst=10, Mem2Reg=10, PCSrc=10, PCWrite=1.
- Illegal opcode 0x3F, and R-type with func 0x3F: each goes DECODE→TRAP with illegal=1; the block stays in state 15 with zero strobes until reset.
- TIMEOUT=4, `mem_ready` held 0 in FETCH: TRAP entered after 4 FETCH cycles with bus_error=1. Repeat with `mem_ready`=1 on the 4th cycle: goes to DECODE, no error.
- Reset asserted during MEM_WRITE (sw): MemWrite=0 in the reset cycle; FETCH on the first cycle after release; illegal=bus_error=0.
